// File: rtl/axi_sram_slave.sv
`default_nettype none
// ============================================================================
// Module      : axi_sram_slave
// Description : AXI3 slave fronting a 2**ADDR_W x 32-bit SRAM. INCR word
//               bursts. Independent read and write FSMs.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_sram_slave #(
    parameter int ADDR_W = 16
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic        awvalid,
    output logic        awready,
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);
    localparam int c_DEPTH = 2**ADDR_W;

    typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} rd_state_t;
    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wr_state_t;

    logic [31:0]       r_mem [c_DEPTH];
    logic              r_alive;

    rd_state_t         r_rd_state, w_rd_state_nx;
    logic [ADDR_W-1:0] r_rd_idx, w_rd_idx_nx;
    logic [3:0]        r_rd_cnt, w_rd_cnt_nx;
    logic [3:0]        r_rid;
    logic [31:0]       r_rdata;
    logic              w_rd_load;
    logic              w_ar_hs;

    wr_state_t         r_wr_state, w_wr_state_nx;
    logic [ADDR_W-1:0] r_wr_idx, w_wr_idx_nx;
    logic [3:0]        r_wr_cnt, w_wr_cnt_nx;
    logic [3:0]        r_bid;
    logic              r_mismatch;
    logic              w_aw_hs;
    logic              w_wr_beat;

    // Lane/ID/upper-address bits the slave does not interpret.
    logic w_unused;
    assign w_unused = ^{wid, arlen, awlen, araddr, awaddr};

    // Holds the address channels closed until the first edge after reset.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) r_alive <= 1'b0;
        else          r_alive <= 1'b1;
    end

    // ---------------------------------------------------------------- read
    assign arready = r_alive && (r_rd_state == R_IDLE);
    assign rvalid  = (r_rd_state == R_DATA);
    assign rlast   = rvalid && (r_rd_cnt == 4'd0);
    assign rid     = r_rid;
    assign rdata   = r_rdata;
    assign rresp   = 2'b00;
    assign w_ar_hs = arvalid && arready;

    always_comb begin
        w_rd_state_nx = r_rd_state;
        w_rd_idx_nx   = r_rd_idx;
        w_rd_cnt_nx   = r_rd_cnt;
        w_rd_load     = 1'b0;
        case (r_rd_state)
            R_IDLE: begin
                if (w_ar_hs) begin
                    w_rd_state_nx = R_DATA;
                    w_rd_idx_nx   = araddr[ADDR_W+1:2];
                    w_rd_cnt_nx   = arlen[3:0];
                    w_rd_load     = 1'b1;
                end
            end
            R_DATA: begin
                if (rready) begin
                    if (r_rd_cnt != 4'd0) begin
                        w_rd_idx_nx = r_rd_idx + ADDR_W'(1);
                        w_rd_cnt_nx = r_rd_cnt - 4'd1;
                        w_rd_load   = 1'b1;
                    end else begin
                        w_rd_state_nx = R_IDLE;
                    end
                end
            end
            default: w_rd_state_nx = R_IDLE;
        endcase
    end

    // Non-blocking load sees pre-write contents when a write hits the same word.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rd_state <= R_IDLE;
            r_rd_idx   <= '0;
            r_rd_cnt   <= 4'd0;
            r_rid      <= 4'd0;
            r_rdata    <= 32'd0;
        end else begin
            r_rd_state <= w_rd_state_nx;
            r_rd_idx   <= w_rd_idx_nx;
            r_rd_cnt   <= w_rd_cnt_nx;
            if (w_ar_hs)   r_rid   <= arid;
            if (w_rd_load) r_rdata <= r_mem[w_rd_idx_nx];
        end
    end

    // --------------------------------------------------------------- write
    assign awready   = r_alive && (r_wr_state == W_IDLE);
    assign wready    = (r_wr_state == W_DATA);
    assign bvalid    = (r_wr_state == W_RESP);
    assign bid       = r_bid;
    assign bresp     = (bvalid && r_mismatch) ? 2'b10 : 2'b00;
    assign w_aw_hs   = awvalid && awready;
    assign w_wr_beat = wvalid && wready;

    always_comb begin
        w_wr_state_nx = r_wr_state;
        w_wr_idx_nx   = r_wr_idx;
        w_wr_cnt_nx   = r_wr_cnt;
        case (r_wr_state)
            W_IDLE: begin
                if (w_aw_hs) begin
                    w_wr_state_nx = W_DATA;
                    w_wr_idx_nx   = awaddr[ADDR_W+1:2];
                    w_wr_cnt_nx   = awlen[3:0];
                end
            end
            W_DATA: begin
                if (wvalid) begin
                    if (r_wr_cnt == 4'd0) begin
                        w_wr_state_nx = W_RESP;
                    end else begin
                        w_wr_idx_nx = r_wr_idx + ADDR_W'(1);
                        w_wr_cnt_nx = r_wr_cnt - 4'd1;
                    end
                end
            end
            W_RESP: begin
                if (bready) w_wr_state_nx = W_IDLE;
            end
            default: w_wr_state_nx = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wr_state <= W_IDLE;
            r_wr_idx   <= '0;
            r_wr_cnt   <= 4'd0;
            r_bid      <= 4'd0;
            r_mismatch <= 1'b0;
        end else begin
            r_wr_state <= w_wr_state_nx;
            r_wr_idx   <= w_wr_idx_nx;
            r_wr_cnt   <= w_wr_cnt_nx;
            if (w_aw_hs) begin
                r_bid      <= awid;
                r_mismatch <= 1'b0;
            end else if (w_wr_beat && (wlast != (r_wr_cnt == 4'd0))) begin
                r_mismatch <= 1'b1;
            end
        end
    end

    // Storage is deliberately outside reset.
    always_ff @(posedge aclk) begin
        if (w_wr_beat) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) r_mem[r_wr_idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/axi_sram_slave.md
AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, meaning word-address bits (memory depth 2**ADDR_W words of 32 bits).
REQ-002 SHALL have port aclk  input  1  sole clock, rising edge.
REQ-003 SHALL have port aresetn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port arid  input  4  read ID.
REQ-005 SHALL have port araddr  input  32  read byte address.
REQ-006 SHALL have port arlen  input  8  read beats minus 1; only bits [3:0] used.
REQ-007 SHALL have port arvalid  input  1  read address valid.
REQ-008 SHALL have port arready  output  1  read address accept.
REQ-009 SHALL have port rid  output  4  read response ID.
REQ-010 SHALL have port rdata  output  32  read data.
REQ-011 SHALL have port rresp  output  2  read response, always 2'b00.
REQ-012 SHALL have port rlast  output  1  final read beat.
REQ-013 SHALL have port rvalid  output  1  read data valid.
REQ-014 SHALL have port rready  input  1  master accepts read data.
REQ-015 SHALL have port awid  input  4  write ID.
REQ-016 SHALL have port awaddr  input  32  write byte address.
REQ-017 SHALL have port awlen  input  8  write beats minus 1; only bits [3:0] used.
REQ-018 SHALL have port awvalid  input  1  write address valid.
REQ-019 SHALL have port awready  output  1  write address accept.
REQ-020 SHALL have port wid  input  4  write data ID, ignored.
REQ-021 SHALL have port wdata  input  32  write data.
REQ-022 SHALL have port wstrb  input  4  byte enables; bit n covers wdata[8n+7:8n].
REQ-023 SHALL have port wlast  input  1  master's last-beat marker.
REQ-024 SHALL have port wvalid  input  1  write data valid.
REQ-025 SHALL have port wready  output  1  write data accept.
REQ-026 SHALL have port bid  output  4  write response ID.
REQ-027 SHALL have port bresp  output  2  write response.
REQ-028 SHALL have port bvalid  output  1  write response valid.
REQ-029 SHALL have port bready  input  1  master accepts write response.

Function
REQ-030 Burst type SHALL be INCR, word-sized; word index = addr[ADDR_W+1:2]; upper address bits ignored; index increments per beat, wrapping modulo 2**ADDR_W.
REQ-031 Read and write channels SHALL run as independent FSMs, operating concurrently.
REQ-032 Read FSM R_IDLE: arready=1; arvalid&arready latches arid, index, beat count=arlen[3:0], loads rdata=mem[index] -> R_DATA.
REQ-033 R_DATA: rvalid=1, arready=0, rid=latched ID, rlast=(count==0); first rvalid SHALL appear the cycle after AR handshake.
REQ-034 R_DATA: rdata/rid/rlast SHALL hold stable while rvalid&!rready; on rvalid&rready with count!=0, index+1, count-1, rdata reloaded from new index (back-to-back beats, no bubble); with count==0 -> R_IDLE.
REQ-035 Write FSM W_IDLE: awready=1; awvalid&awready latches awid, index, count=awlen[3:0] -> W_DATA.
REQ-036 W_DATA: wready=1; each wvalid&wready writes bytes with wstrb set, index+1, count-1; beat at count==0 -> W_RESP; wlast SHALL NOT terminate the burst.
REQ-037 Mismatch flag SHALL set when wlast disagrees with (count==0) on any accepted beat; cleared at AW handshake.
REQ-038 W_RESP: bvalid=1, bid=latched ID, bresp=2'b10 if mismatch flag else 2'b00; bvalid&bready -> W_IDLE.
REQ-039 Read beat load and write beat on same word in same cycle: loaded rdata SHALL be pre-write contents.
REQ-040 At most one outstanding transaction per channel; no address accepted until the prior one completes (one idle cycle between bursts).

Reset
REQ-041 aresetn=0 SHALL force immediately: FSMs to R_IDLE/W_IDLE, rvalid=0, bvalid=0, wready=0, rlast=0, rid=0, bid=0, rdata=0, bresp=0, arready=0, awready=0.
REQ-042 arready/awready SHALL rise at the first aclk edge after aresetn deasserts; memory contents SHALL NOT be reset; reset mid-burst abandons the transaction with no response.

Verification
REQ-043 Reset: aresetn=0 mid-read-burst -> rvalid=0 asynchronously; release -> arready=awready=1 one edge later.
REQ-044 Write 0x100, awlen=0, wdata=0xDEADBEEF, wstrb=4'hF, wlast=1, awid=3 -> bvalid, bid=3, bresp=0; read 0x100 arid=5 -> rvalid 1 cycle after AR, rdata=0xDEADBEEF, rid=5, rlast=1.
REQ-045 Write 0x11223344 to 0x40, then wdata=0x0000AA00 wstrb=4'b0010 -> read returns 0x1122AA44.
REQ-046 Preload 0x200..0x20C with 1,2,3,4; read arlen=3 with rready 1,0,1,1,1 -> beats 1,2,3,4, rdata stable over stall, rlast only on 4, arready=0 until return to R_IDLE.
REQ-047 Write awlen=1 with wlast=1 on first beat -> two beats accepted and written, bresp=2'b10; next correct burst -> bresp=2'b00.
REQ-048 Read top word (index 2**ADDR_W-1), arlen=1 -> second beat returns word 0.
